// File: rtl/imm_gen_pkg.sv
// -----------------------------------------------------------------------------
// imm_gen_pkg
// Shared definitions for the ID-stage immediate generator.
//   - RV32I/RV64I major opcode constants
//   - imm_type_e : 3-bit immediate format encoding (NONE=0 I=1 S=2 B=3 U=4 J=5)
//   - imm_entry_t: one buffered result {imm, imm_type, tag, illegal}
// Optional feature macro: IMM_GEN_ILLEGAL_EN adds the illegal flag to the entry.
// Entry fields are sized for the widest legal configuration (XLEN=64,
// TAG_W<=16); the top narrows them back to its own parameters.
// -----------------------------------------------------------------------------
package imm_gen_pkg;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;
   localparam logic [6:0] OPC_OP        = 7'b0110011;
   localparam logic [6:0] OPC_OP_32     = 7'b0111011;
   localparam logic [6:0] OPC_SYSTEM    = 7'b1110011;
   localparam logic [6:0] OPC_MISC_MEM  = 7'b0001111;

   localparam int IMM_MAX_W = 64;
   localparam int TAG_MAX_W = 16;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_type_e;

   typedef struct packed {
      logic [IMM_MAX_W-1:0] imm;
      imm_type_e            imm_type;
      logic [TAG_MAX_W-1:0] tag;
`ifdef IMM_GEN_ILLEGAL_EN
      logic                 illegal;
`endif
   } imm_entry_t;

   function automatic logic [6:0] opcode_of(input logic [31:0] ins);
      return ins[6:0];
   endfunction

endpackage

// File: rtl/imm_gen_pipe_decode.sv
// -----------------------------------------------------------------------------
// imm_decode
// Purely combinational immediate decoder. Bit 31 of the instruction is always
// the sign source; every format is sign-extended to XLEN.
// Optional feature macro: IMM_GEN_ILLEGAL_EN adds the illegal output.
// Ports:
//   instr    in   32     raw instruction word
//   imm      out  XLEN   sign-extended immediate (0 for no-immediate opcodes)
//   imm_type out  3      imm_type_e format
//   illegal  out  1      unknown opcode (only with IMM_GEN_ILLEGAL_EN)
// -----------------------------------------------------------------------------
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output imm_type_e       imm_type
`ifdef IMM_GEN_ILLEGAL_EN
   ,
   output logic            illegal
`endif
);

   logic [6:0] opcode;
   assign opcode = opcode_of(instr);

   // Size casts of signed slices perform the sign extension to XLEN.
   always_comb begin
      imm      = '0;
      imm_type = IMM_NONE;
      case (opcode)
         OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
            imm      = XLEN'($signed(instr[31:20]));
            imm_type = IMM_I;
         end
         OPC_OP_IMM_32: begin
            // ADDIW and friends only exist on RV64.
            if (XLEN == 64) begin
               imm      = XLEN'($signed(instr[31:20]));
               imm_type = IMM_I;
            end
         end
         OPC_STORE: begin
            imm      = XLEN'($signed({instr[31:25], instr[11:7]}));
            imm_type = IMM_S;
         end
         OPC_BRANCH: begin
            imm      = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
            imm_type = IMM_B;
         end
         OPC_LUI, OPC_AUIPC: begin
            imm      = XLEN'($signed({instr[31:12], 12'b0}));
            imm_type = IMM_U;
         end
         OPC_JAL: begin
            imm      = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
            imm_type = IMM_J;
         end
         default: begin
            imm      = '0;
            imm_type = IMM_NONE;
         end
      endcase
   end

`ifdef IMM_GEN_ILLEGAL_EN
   // Legal = any opcode in the decode table above, plus the no-immediate
   // R-type, SYSTEM and MISC-MEM groups. Low bits != 2'b11 never match.
   always_comb begin
      illegal = 1'b1;
      case (opcode)
         OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_STORE, OPC_BRANCH,
         OPC_LUI, OPC_AUIPC, OPC_JAL,
         OPC_OP, OPC_OP_32, OPC_SYSTEM, OPC_MISC_MEM: illegal = 1'b0;
         OPC_OP_IMM_32:                               illegal = (XLEN != 64);
         default:                                     illegal = 1'b1;
      endcase
      if (instr[1:0] != 2'b11) illegal = 1'b1;
   end
`endif

endmodule

// File: rtl/imm_gen_pipe.sv
// -----------------------------------------------------------------------------
// imm_gen_pipe
// Registered RV32I/RV64I immediate generator for the ID stage. Decoded results
// sit in a 2-entry skid buffer (main + skid) behind a valid/ready handshake.
// Optional feature macro: IMM_GEN_ILLEGAL_EN adds the registered illegal port.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The producer holds its payload while valid is high and ready is low;
// ready never depends combinationally on valid. in_ready is a flop equal to
// "skid register empty", so downstream stalls never reach upstream in the same
// cycle. flush empties both registers on the next edge and drops any input in
// that cycle; reset has priority over flush.
//
// Ports:
//   clk, reset              rising-edge clock, synchronous active-high reset
//   flush                   drop every buffered entry
//   in_valid/in_ready       input handshake for instr + in_tag
//   instr [31:0]            raw instruction word
//   in_tag [TAG_W-1:0]      sideband passed through unchanged
//   out_valid/out_ready     output handshake for imm/imm_type/out_tag
//   imm [XLEN-1:0]          sign-extended immediate
//   imm_type [2:0]          NONE=0 I=1 S=2 B=3 U=4 J=5
//   out_tag [TAG_W-1:0]     tag of the presented entry
//   illegal                 unknown opcode (only with IMM_GEN_ILLEGAL_EN)
// Parameters: XLEN (32 or 64), TAG_W (1..16).
// -----------------------------------------------------------------------------
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      instr,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [XLEN-1:0]  imm,
   output logic [2:0]       imm_type,
   output logic [TAG_W-1:0] out_tag
`ifdef IMM_GEN_ILLEGAL_EN
   ,
   output logic             illegal
`endif
);

   logic [XLEN-1:0] dec_imm;
   imm_type_e       dec_type;
`ifdef IMM_GEN_ILLEGAL_EN
   logic            dec_illegal;
`endif

   imm_decode #(.XLEN(XLEN)) u_decode (
      .instr    (instr),
      .imm      (dec_imm),
      .imm_type (dec_type)
`ifdef IMM_GEN_ILLEGAL_EN
      ,
      .illegal  (dec_illegal)
`endif
   );

   imm_entry_t dec_entry;
   always_comb begin
      dec_entry          = '0;
      dec_entry.imm      = IMM_MAX_W'(dec_imm);
      dec_entry.imm_type = dec_type;
      dec_entry.tag      = TAG_MAX_W'(in_tag);
`ifdef IMM_GEN_ILLEGAL_EN
      dec_entry.illegal  = dec_illegal;
`endif
   end

   imm_entry_t main_q;
   imm_entry_t skid_q;
   logic       main_valid_q;
   logic       skid_valid_q;
   logic       in_ready_q;

   logic in_xfer;
   logic out_xfer;
   logic main_free;

   assign in_xfer   = in_valid & in_ready_q;
   assign out_xfer  = main_valid_q & out_ready;
   // Main can take a new entry when empty or when its entry leaves this cycle.
   assign main_free = ~main_valid_q | out_xfer;

   always_ff @(posedge clk) begin
      if (reset) begin
         main_q       <= '0;
         skid_q       <= '0;
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else if (flush) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         in_ready_q   <= 1'b1;
      end else if (main_free) begin
         if (skid_valid_q) begin
            // in_ready was low, so no input can arrive alongside this move.
            main_q       <= skid_q;
            main_valid_q <= 1'b1;
            skid_valid_q <= 1'b0;
            in_ready_q   <= 1'b1;
         end else if (in_xfer) begin
            main_q       <= dec_entry;
            main_valid_q <= 1'b1;
         end else begin
            main_valid_q <= 1'b0;
         end
      end else if (in_xfer) begin
         // Main is stalled: park the new entry and close the input.
         skid_q       <= dec_entry;
         skid_valid_q <= 1'b1;
         in_ready_q   <= 1'b0;
      end
   end

   assign in_ready  = in_ready_q;
   assign out_valid = main_valid_q;
   assign imm       = XLEN'(main_q.imm);
   assign imm_type  = main_q.imm_type;
   assign out_tag   = TAG_W'(main_q.tag);
`ifdef IMM_GEN_ILLEGAL_EN
   assign illegal   = main_q.illegal;
`endif

endmodule
